// File: rtl/dh_modexp_if.sv
// dh_modexp_if: request/response bundle for the modular exponentiator.
//   start    : request strobe, sampled only while the engine is idle
//   base     : base operand (W bits, must be < modulus)
//   exponent : exponent operand (W bits, unsigned)
//   modulus  : modulus operand (W bits, must be >= 2)
//   busy     : computation in progress
//   done     : one-cycle completion pulse
//   error    : illegal operands, valid with done
//   result   : base^exponent mod modulus, held until the next accepted start
interface dh_modexp_if #(
  parameter int W = 32
);
  logic         start;
  logic [W-1:0] base;
  logic [W-1:0] exponent;
  logic [W-1:0] modulus;
  logic         busy;
  logic         done;
  logic         error;
  logic [W-1:0] result;

  modport master (
    output start, base, exponent, modulus,
    input  busy, done, error, result
  );

  modport slave (
    input  start, base, exponent, modulus,
    output busy, done, error, result
  );
endinterface

// File: rtl/dh_modexp.sv
// dh_modexp: constant-time right-to-left square-and-multiply modular
// exponentiator (result = base^exponent mod modulus).
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : dh_modexp_if slave (start/base/exponent/modulus in,
//         busy/done/error/result out)
// Latency for a legal request is 2 + W*W cycles from the start cycle to the
// done pulse, independent of operand values.
module dh_modexp #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  dh_modexp_if.slave   bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  // One bit-serial interleaved modular multiply step, MSB first.
  // p < m on entry, so every intermediate stays below 2m.
  function automatic logic [W:0] mod_step(input logic [W:0]   p,
                                          input logic [W-1:0] mcand,
                                          input logic         mbit,
                                          input logic [W-1:0] m);
    logic [W+1:0] t;
    t = {p, 1'b0};
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    if (mbit) begin
      t = t + {2'b00, mcand};
      if (t >= {2'b00, m}) t = t - {2'b00, m};
    end
    return t[W:0];
  endfunction

  logic [1:0]    r_state;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic [W-1:0]  r_res;
  logic [CW-1:0] r_bit;
  logic [CW-1:0] r_pass;

  logic [W-1:0]  r_m;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_e;
  logic [W-1:0]  r_r;
  logic [W:0]    r_pa;
  logic [W:0]    r_pb;

  logic [CW-1:0] w_idx;
  logic          w_mbit;
  logic [W:0]    w_pa_nxt;
  logic [W:0]    w_pb_nxt;
  logic          w_last_bit;
  logic          w_last_pass;
  logic [W-1:0]  w_r_nxt;
  logic          w_bad_ops;

  // Both multipliers walk the bits of B, so they share one selected bit.
  assign w_idx       = CW'(W - 1) - r_bit;
  assign w_mbit      = r_b[w_idx];
  assign w_pa_nxt    = mod_step(r_pa, r_r, w_mbit, r_m);
  assign w_pb_nxt    = mod_step(r_pb, r_b, w_mbit, r_m);
  assign w_last_bit  = (r_bit == CW'(W - 1));
  assign w_last_pass = (r_pass == CW'(W - 1));
  // Multiply is always performed; only the commit depends on E[0].
  assign w_r_nxt     = r_e[0] ? w_pa_nxt[W-1:0] : r_r;
  assign w_bad_ops   = (r_m < W'(2)) || (r_b >= r_m);

  // Control: state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_res   <= '0;
      r_bit   <= '0;
      r_pass  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (w_bad_ops) begin
            r_state <= S_FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_res   <= '0;
          end else begin
            r_state <= S_RUN;
            r_err   <= 1'b0;
            r_bit   <= '0;
            r_pass  <= '0;
          end
        end
        S_RUN: begin
          if (w_last_bit) begin
            r_bit  <= '0;
            r_pass <= r_pass + 1'b1;
            if (w_last_pass) begin
              r_state <= S_FIN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_res   <= w_r_nxt;
            end
          end else begin
            r_bit <= r_bit + 1'b1;
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Datapath: operand latches, running R/B/E and the two accumulators.
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          r_b <= bus.base;
          r_e <= bus.exponent;
          r_m <= bus.modulus;
        end
      end
      S_LOAD: begin
        r_r  <= W'(1);
        r_pa <= '0;
        r_pb <= '0;
      end
      S_RUN: begin
        if (w_last_bit) begin
          r_pa <= '0;
          r_pb <= '0;
          r_r  <= w_r_nxt;
          r_b  <= w_pb_nxt[W-1:0];
          r_e  <= r_e >> 1;
        end else begin
          r_pa <= w_pa_nxt;
          r_pb <= w_pb_nxt;
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.error  = r_err;
  assign bus.result = r_res;

endmodule

// File: tb/tb_dh_modexp.sv
// tb_dh_modexp: self-checking bench for dh_modexp at W=8. Directed and
// random requests are compared against a repeated-multiplication model.
module tb_dh_modexp;

  localparam int W   = 8;
  localparam int LAT = 2 + W * W;
  localparam int TMO = 200;

  logic clk = 1'b0;
  logic rst;
  int   n_tot = 0;
  int   n_bad = 0;

  dh_modexp_if #(.W(W)) bus ();

  dh_modexp #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int ref_pow(input int b, input int e, input int m);
    longint r;
    r = 1 % m;
    for (int i = 0; i < e; i++) r = (r * b) % m;
    return int'(r);
  endfunction

  // Issue one request; returns in the done cycle (or on timeout).
  task automatic run_op(input int b, input int e, input int m, input bit poke,
                        output int res, output int err, output int lat, output int busy_bad);
    bus.base     = W'(b);
    bus.exponent = W'(e);
    bus.modulus  = W'(m);
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat       = 1;
    busy_bad  = (bus.busy !== 1'b1) ? 1 : 0;
    while (bus.done !== 1'b1 && lat < TMO) begin
      if (poke && lat == 20) begin
        bus.start    = 1'b1;
        bus.base     = W'($urandom);
        bus.exponent = W'($urandom);
        bus.modulus  = W'($urandom);
      end
      if (poke && lat == 21) bus.start = 1'b0;
      @(posedge clk);
      #1;
      lat++;
      if (bus.done !== 1'b1 && bus.busy !== 1'b1) busy_bad++;
      if (bus.done === 1'b1 && bus.busy !== 1'b0) busy_bad++;
    end
    bus.start = 1'b0;
    res = int'(bus.result);
    err = int'(bus.error);
  endtask

  // exp_res < 0 selects the reference model.
  task automatic check_op(input string tag, input int b, input int e, input int m,
                          input int exp_res, input bit poke);
    int res, err, lat, bb;
    int x_err, x_res, x_lat;
    x_err = (m < 2 || b >= m) ? 1 : 0;
    if (x_err != 0)      x_res = 0;
    else if (exp_res < 0) x_res = ref_pow(b, e, m);
    else                 x_res = exp_res;
    x_lat = (x_err != 0) ? 2 : LAT;
    run_op(b, e, m, poke, res, err, lat, bb);
    chk({tag, ".res"},  64'(res), 64'(x_res));
    chk({tag, ".err"},  64'(err), 64'(x_err));
    chk({tag, ".lat"},  64'(lat), 64'(x_lat));
    chk({tag, ".busy"}, 64'(bb),  64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int res, err, lat, bb, pulses, m, b, e;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.base     = '0;
    bus.exponent = '0;
    bus.modulus  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy",   64'(bus.busy),   64'(0));
    chk("rst.done",   64'(bus.done),   64'(0));
    chk("rst.error",  64'(bus.error),  64'(0));
    chk("rst.result", 64'(bus.result), 64'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    check_op("basic",    5,   6,  23,  8, 1'b0);
    check_op("pubA",     5,  15,  23, 19, 1'b0);
    check_op("shA",     19,   6,  23,  2, 1'b0);
    check_op("shB",      8,  15,  23,  2, 1'b0);
    check_op("exp0",     7,   0,  11,  1, 1'b0);
    check_op("base0",    0,   5,  13,  0, 1'b0);
    check_op("p251",     2,   8, 251,  5, 1'b0);
    check_op("ones",     3, 255, 254, -1, 1'b0);
    check_op("badm",     4,   5,   1,  0, 1'b0);
    check_op("badb",    30,   5,  23,  0, 1'b0);
    check_op("after",    3,   5,   7,  5, 1'b0);
    check_op("poke",     5,   6,  23,  8, 1'b1);

    // start during FIN must be ignored
    run_op(3, 5, 7, 1'b0, res, err, lat, bb);
    chk("fin.res", 64'(res), 64'(5));
    bus.base = 8'd2; bus.exponent = 8'd3; bus.modulus = 8'd11;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("fin.busy", 64'(bus.busy), 64'(0));
    pulses = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
    end
    chk("fin.quiet", 64'(pulses), 64'(0));
    chk("fin.hold",  64'(bus.result), 64'(5));

    // reset in cycle 30 of a run
    bus.base = 8'd3; bus.exponent = 8'd200; bus.modulus = 8'd101;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 1;
    while (lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid.busy",   64'(bus.busy),   64'(0));
    chk("mid.done",   64'(bus.done),   64'(0));
    chk("mid.error",  64'(bus.error),  64'(0));
    chk("mid.result", 64'(bus.result), 64'(0));
    pulses = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) pulses++;
    end
    chk("mid.nodone", 64'(pulses), 64'(0));
    check_op("postrst", 3, 200, 101, -1, 1'b0);

    // reset and start together: request dropped
    rst = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.start = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.busy === 1'b1 || bus.done === 1'b1) pulses++;
    end
    chk("rststart", 64'(pulses), 64'(0));

    // randomized requests, some illegal
    for (int i = 0; i < 20; i++) begin
      m = $urandom_range(2, 255);
      b = $urandom_range(0, m - 1);
      e = $urandom_range(0, 255);
      if (i % 5 == 4) begin
        if (i % 2 == 1) m = $urandom_range(0, 1);
        else if (m < 255) b = $urandom_range(m, 255);
      end
      check_op($sformatf("rnd%0d", i), b, e, m, -1, (i % 3 == 0) ? 1'b1 : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
